// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by clearing its two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory and decode-side handshake bundle of the fetch controller.
// master: the fetch controller; slave: memory plus decode consumer.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries. Flush wins over push/pop.
// A push while full is accepted only together with a pop; the write then
// lands in the slot being vacated by the head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_eff_s;
  logic             push_eff_s;

  assign full       = (count_r == CNT_W'(DEPTH));
  assign empty      = (count_r == CNT_W'(0));
  assign count      = count_r;
  assign pop_eff_s  = pop && !empty && !flush;
  assign push_eff_s = push && !flush && (!full || pop_eff_s);

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_eff_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_eff_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_eff_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_eff_s, pop_eff_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation; reads zero while the queue is empty.
  always_comb begin
    head = '0;
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: owns the fetch PC, drives the combinational instruction
// memory, queues {pc, instr} pairs and hands them to decode.
// Optional build macro FETCH_CTRL_PERF_EN adds perf_fetched / perf_stall.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              FQ_DEPTH  = 4,
  parameter logic [XLEN-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  fetch_controller_if.master             fif,
  output logic                           halted,
  output logic [$clog2(FQ_DEPTH+1)-1:0]  fq_count
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]                    perf_fetched,
  output logic [31:0]                    perf_stall
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  fetch_state_e     state_r;
  fetch_state_e     state_next_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_next_s;
  logic             halted_r;
  logic             push_s;
  logic             pop_s;
  logic             q_full_s;
  logic             q_empty_s;
  logic [CNT_W-1:0] q_count_s;
  fetch_entry_t     q_head_s;
  fetch_entry_t     push_entry_s;

  assign pop_s            = !q_empty_s && fif.out_ready;
  assign push_entry_s.pc    = pc_r;
  assign push_entry_s.instr = fif.imem_data;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (q_head_s),
    .count     (q_count_s),
    .full      (q_full_s),
    .empty     (q_empty_s)
  );

  // Next-state, next-PC and push decision; redirect overrides every state.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    push_s       = 1'b0;
    if (redirect_valid) begin
      state_next_s = FETCH;
      pc_next_s    = align_pc(redirect_pc);
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_next_s = FETCH;
          end else begin
            state_next_s = IDLE;
          end
        end
        FETCH: begin
          if (!q_full_s || pop_s) begin
            push_s    = 1'b1;
            pc_next_s = pc_r + 32'd4;
            if (fif.imem_data == HALT_WORD) begin
              state_next_s = HALT;
            end else begin
              state_next_s = FETCH;
            end
          end else begin
            state_next_s = FETCH;
          end
        end
        HALT:    state_next_s = HALT;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State, PC and halted flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pc_r     <= pc_next_s;
      halted_r <= (state_next_s == HALT);
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Free-running event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      if (push_s) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if ((state_r == FETCH) && !redirect_valid && q_full_s && !pop_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`endif

  assign fif.imem_addr = pc_r;
  assign fif.out_valid = !q_empty_s;
  assign fif.out_pc    = q_head_s.pc;
  assign fif.out_instr = q_head_s.instr;
  assign halted        = halted_r;
  assign fq_count      = q_count_s;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the combinational instruction memory.
- Owns the fetch PC, drives the word-aligned memory address each cycle, and captures {pc, instruction} pairs into a small fetch queue.
- Presents queue entries to decode with a valid/ready handshake.
- Handles redirects (branch/flush) and a halt instruction. Sits between instruction memory and the decode/rename front end.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FQ_DEPTH, 4, fetch queue entries; power of two, 2..16.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching.
- redirect_valid  input  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced to 0).
- imem_addr  output  32  byte address to instruction memory; always equals the PC register.
- imem_data  input  32  instruction returned combinationally for imem_addr.
- out_valid  output  1  queue head valid.
- out_ready  input  1  decode accepts head.
- out_pc  output  32  PC of head entry.
- out_instr  output  32  instruction of head entry.
- halted  output  1  HALT state.
- fq_count  output  $clog2(FQ_DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=IDLE, queue empty.
  - out_valid=0, halted=0, fq_count=0, imem_addr=RESET_PC.
  - out_pc and out_instr read 0 while empty.
  - Reset overrides every other input and takes effect mid-operation (queue contents lost).
- States:
  - IDLE: start=1 -> FETCH. No pushes in IDLE.
  - FETCH: see push rules below.
  - HALT: pc frozen, no pushes, halted=1; queue still drains. Exits only via redirect or rst.
- Pop: occurs when out_valid && out_ready. out_valid = (fq_count != 0). Head entry is registered.
- Push (FETCH only, no redirect): when fq_count < FQ_DEPTH, or fq_count == FQ_DEPTH with a pop in the same cycle.
  - Entry pushed is {pc, imem_data}; pc <= pc + 4.
  - pc wraps 32'hFFFF_FFFC -> 0.
- Stall: when a push is blocked, pc holds and imem_addr is stable. No instruction is lost or duplicated.
- Halt: if the pushed imem_data == HALT_WORD, the entry is still pushed, pc <= pc + 4, and state <= HALT.
- Redirect:
  - Priority is below rst and above everything else.
  - Next cycle: fq_count=0, out_valid=0, pc={redirect_pc[31:2],2'b00}, state=FETCH (from IDLE, FETCH or HALT), halted=0.
  - No push occurs in the redirect cycle.
  - A handshake in the redirect cycle completes for the consumer, but the consumer must discard it (its flush is in the same cycle).
- Latency:
  - Fetch to out_valid: 1 cycle (push at edge N, visible after edge N).
  - start or redirect to first out_valid: 2 cycles.
  - Sustained throughput: 1 instruction/cycle with out_ready=1.
- Simultaneous push and pop: fq_count unchanged. Pointers wrap modulo FQ_DEPTH.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0].
  - perf_fetched: pushes.
  - perf_stall: FETCH-state cycles with push blocked by a full queue.
  - Both reset to 0, wrap at 2^32, are not cleared by redirect, and count only when not in rst.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- fetch_pkg:
  - fetch_state_e (IDLE, FETCH, HALT).
  - XLEN=32.
  - default RESET_PC and HALT_WORD constants.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty.
  - flush has priority over push and pop.
- The controller holds the FSM, PC and optional counters.

Test Plan:
- Stream: memory preloaded with mem[i]=32'h100+i, rst then start, out_ready=1 -> out_valid rises 2 cycles after start; out_pc 0,4,8,... with out_instr 0x100,0x101,0x102,... every cycle.
- Backpressure: out_ready=0 after start -> fq_count reaches 4, imem_addr holds 0x10; then out_ready=1 -> entries 0x0..0x0C drain and 0x10 follows, no gap, duplicate or loss.
- Redirect: queue holding 3 entries, redirect_pc=0x43 -> next cycle fq_count=0 and out_valid=0, imem_addr=0x40; first entry out_pc=0x40, 2 cycles after redirect.
- Halt: mem[2]=HALT_WORD -> entries 0x0, 0x4, 0x8 delivered, halted=1, no further pushes, pc=0x0C; redirect to 0x0 -> halted=0 and fetch resumes at 0x0.
- Reset mid-run: rst with full queue and out_ready=1 -> next cycle out_valid=0, fq_count=0, imem_addr=RESET_PC; no output until start.
- Full plus pop: fq_count=4 with out_ready=1 in FETCH -> push and pop in the same cycle, fq_count stays 4, pc advances by 4 each cycle.
